// File: rtl/axi_pixel_wr_arbiter.sv
// Round-robin arbiter funnelling N_REQ pixel writers into single-beat AXI4 writes,
// with exactly one transaction outstanding at a time.
module axi_pixel_wr_arbiter #(
   parameter int unsigned N_REQ                          = 2,
   parameter logic [31:0] C_M_AXI_TARGET_SLAVE_BASE_ADDR = 32'h40000000
) (
   input  logic                m_axi_aclk,
   input  logic                m_axi_aresetn,
   input  logic [N_REQ-1:0]    req_valid_i,
   output logic [N_REQ-1:0]    req_ready_o,
   input  logic [32*N_REQ-1:0] req_addr_i,
   input  logic [32*N_REQ-1:0] req_data_i,
   input  logic [4*N_REQ-1:0]  req_strb_i,
   output logic [N_REQ-1:0]    req_done_o,
   output logic [N_REQ-1:0]    req_err_o,
   output logic [31:0]         m_axi_awaddr,
   output logic [7:0]          m_axi_awlen,
   output logic [2:0]          m_axi_awsize,
   output logic [1:0]          m_axi_awburst,
   output logic                m_axi_awlock,
   output logic [3:0]          m_axi_awcache,
   output logic [2:0]          m_axi_awprot,
   output logic [3:0]          m_axi_awqos,
   output logic                m_axi_awvalid,
   input  logic                m_axi_awready,
   output logic [31:0]         m_axi_wdata,
   output logic [3:0]          m_axi_wstrb,
   output logic                m_axi_wlast,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   input  logic [1:0]          m_axi_bresp,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready
);
   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
   state_t r_state, w_state_nxt;

   logic [PW-1:0]    r_rr_ptr, r_gidx;
   logic [PW-1:0]    w_gidx, w_lo_idx, w_hi_idx;
   logic             w_found, w_lo_found, w_hi_found;
   logic [31:0]      w_sel_addr, w_sel_data;
   logic [3:0]       w_sel_strb;
   logic [N_REQ-1:0] w_ready;
   logic             w_aw_fin, w_w_fin, w_b_hs;
   logic [31:0]      r_awaddr, r_wdata;
   logic [3:0]       r_wstrb;
   logic             r_awvalid, r_wvalid, r_bready;
   logic [N_REQ-1:0] r_done, r_err;

   // Round-robin: lowest valid index at or above the pointer, else wrap to lowest valid.
   always_comb begin
      w_lo_found = 1'b0;
      w_lo_idx   = '0;
      w_hi_found = 1'b0;
      w_hi_idx   = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (req_valid_i[i] && !w_lo_found) begin
            w_lo_found = 1'b1;
            w_lo_idx   = PW'(i);
         end
         if (req_valid_i[i] && (i >= 32'(r_rr_ptr)) && !w_hi_found) begin
            w_hi_found = 1'b1;
            w_hi_idx   = PW'(i);
         end
      end
      w_found = w_lo_found;
      w_gidx  = w_hi_found ? w_hi_idx : w_lo_idx;
   end

   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      w_sel_strb = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (PW'(i) == w_gidx) begin
            w_sel_addr = req_addr_i[i*32 +: 32];
            w_sel_data = req_data_i[i*32 +: 32];
            w_sel_strb = req_strb_i[i*4 +: 4];
         end
      end
   end

   always_comb begin
      w_ready = '0;
      if ((r_state == IDLE) && w_found && m_axi_aresetn)
         w_ready[w_gidx] = 1'b1;
   end

   assign w_aw_fin = !r_awvalid || m_axi_awready;
   assign w_w_fin  = !r_wvalid || m_axi_wready;
   assign w_b_hs   = r_bready && m_axi_bvalid;

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) r_state <= IDLE;
      else                r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_found) w_state_nxt = XFER;
         XFER:    if (w_aw_fin && w_w_fin) w_state_nxt = RESP;
         RESP:    if (w_b_hs) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         r_rr_ptr  <= '0;
         r_gidx    <= '0;
         r_awaddr  <= C_M_AXI_TARGET_SLAVE_BASE_ADDR;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_done    <= '0;
         r_err     <= '0;
      end else begin
         r_done <= '0;
         r_err  <= '0;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_gidx    <= w_gidx;
                  r_awaddr  <= C_M_AXI_TARGET_SLAVE_BASE_ADDR + (w_sel_addr & 32'hFFFF_FFFC);
                  r_wdata   <= w_sel_data;
                  r_wstrb   <= w_sel_strb;
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
               end
            end
            XFER: begin
               if (m_axi_awready) r_awvalid <= 1'b0;
               if (m_axi_wready)  r_wvalid  <= 1'b0;
               if (w_aw_fin && w_w_fin) r_bready <= 1'b1;
            end
            RESP: begin
               if (w_b_hs) begin
                  r_bready       <= 1'b0;
                  r_done[r_gidx] <= 1'b1;
                  r_err[r_gidx]  <= |m_axi_bresp;
                  r_rr_ptr       <= (r_gidx == PW'(N_REQ - 1)) ? '0 : r_gidx + PW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready_o   = w_ready;
   assign req_done_o    = r_done;
   assign req_err_o     = r_err;
   assign m_axi_awaddr  = r_awaddr;
   assign m_axi_awlen   = 8'h00;
   assign m_axi_awsize  = 3'h2;
   assign m_axi_awburst = 2'h1;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'h2;
   assign m_axi_awprot  = 3'h0;
   assign m_axi_awqos   = 4'h0;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wstrb   = r_wstrb;
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_wlast   = r_wvalid;
   assign m_axi_bready  = r_bready;

endmodule

// File: tb/tb_axi_pixel_wr_arbiter.sv
// Self-checking bench for axi_pixel_wr_arbiter: directed vector table, reset corner
// cases and randomized traffic against a transaction-level reference model.
module tb_axi_pixel_wr_arbiter;
   localparam int unsigned N    = 2;
   localparam logic [31:0] BASE = 32'h40000000;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid, req_ready, req_done, req_err;
   logic [32*N-1:0] req_addr, req_data;
   logic [4*N-1:0]  req_strb;
   logic [31:0]     awaddr, wdata;
   logic [7:0]      awlen;
   logic [2:0]      awsize, awprot;
   logic [1:0]      awburst, bresp;
   logic            awlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [3:0]      awcache, awqos, wstrb;

   always #5 clk = ~clk;

   axi_pixel_wr_arbiter #(.N_REQ(N), .C_M_AXI_TARGET_SLAVE_BASE_ADDR(BASE)) dut (
      .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
      .req_data_i(req_data), .req_strb_i(req_strb), .req_done_o(req_done), .req_err_o(req_err),
      .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
      .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awqos(awqos),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
      .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
   );

   int unsigned n_vec = 0, n_bad = 0, cyc = 0;
   logic [N-1:0]    d_valid = '0;
   logic [32*N-1:0] d_addr = '0, d_data = '0;
   logic [4*N-1:0]  d_strb = '0;
   logic            rnd = 1'b0;

   // slave behaviour
   int unsigned aw_dly = 0, w_dly = 0, b_dly = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   logic [1:0]  b_resp = 2'b00;
   logic        s_aw_seen = 0, s_w_seen = 0, s_b_pend = 0;

   // reference model: one transaction in flight, tracked by its phases
   logic        m_busy = 0, m_aw_pend = 0, m_w_pend = 0, m_b_wait = 0;
   int unsigned m_ptr = 0, m_idx = 0;
   logic [31:0] m_addr = '0, m_data = '0;
   logic [3:0]  m_strb = '0;
   logic [N-1:0] m_done_exp = '0, m_err_exp = '0;

   // observations of the DUT for directed checks
   int unsigned obs_acc_n, obs_done_n, obs_acc_cyc, obs_done_cyc, obs_aw_hi, obs_w_hi, obs_br_cyc;
   logic        obs_br_seen;
   logic [31:0] obs_awaddr, obs_wdata;
   logic [3:0]  obs_wstrb;
   logic [N-1:0] obs_done, obs_err, last_hs;
   int          grant_log[$];

   typedef struct {
      int unsigned idx;
      logic [31:0] addr, data;
      logic [3:0]  strb;
      int unsigned aw_dly, w_dly, b_dly;
      logic [1:0]  resp;
      logic [31:0] exp_awaddr;
      int unsigned exp_aw_hi, exp_w_hi, exp_br, exp_lat;
      logic        exp_err;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int unsigned ptr);
      for (int unsigned k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return int'((ptr + k) % N);
      return -1;
   endfunction

   task automatic obs_clear();
      obs_acc_n = 0; obs_done_n = 0; obs_aw_hi = 0; obs_w_hi = 0; obs_br_seen = 0;
      obs_acc_cyc = 0; obs_done_cyc = 0; obs_br_cyc = 0;
      grant_log.delete();
   endtask

   task automatic model_clear();
      m_busy = 0; m_aw_pend = 0; m_w_pend = 0; m_b_wait = 0; m_ptr = 0;
      m_done_exp = '0; m_err_exp = '0;
      s_aw_seen = 0; s_w_seen = 0; s_b_pend = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
   endtask

   task automatic step();
      int g;
      logic [N-1:0] exp_ready;
      logic hs_aw, hs_w, hs_b;
      logic [1:0] resp_now;
      @(negedge clk);
      req_valid = d_valid; req_addr = d_addr; req_data = d_data; req_strb = d_strb;
      awready = awvalid && (aw_cnt >= aw_dly);
      wready  = wvalid && (w_cnt >= w_dly);
      bvalid  = s_b_pend && (b_cnt >= b_dly);
      bresp   = bvalid ? b_resp : 2'b00;
      #1;
      cyc++;
      g = m_busy ? -1 : pick(req_valid, m_ptr);
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("ready", req_ready, exp_ready);
      chk("awvalid", awvalid, m_aw_pend);
      chk("wvalid", wvalid, m_w_pend);
      chk("wlast", wlast, m_w_pend);
      chk("bready", bready, m_b_wait);
      chk("done", req_done, m_done_exp);
      chk("err", req_err, m_err_exp);
      if (m_aw_pend) chk("awaddr", awaddr, m_addr);
      if (m_w_pend) begin
         chk("wdata", wdata, m_data);
         chk("wstrb", wstrb, m_strb);
      end
      last_hs = req_valid & req_ready;
      for (int i = 0; i < N; i++)
         if (last_hs[i]) begin obs_acc_n++; obs_acc_cyc = cyc; grant_log.push_back(i); end
      if (awvalid) obs_aw_hi++;
      if (wvalid) obs_w_hi++;
      if (bready && !obs_br_seen) begin obs_br_seen = 1; obs_br_cyc = cyc; end
      if (awvalid && awready) obs_awaddr = awaddr;
      if (wvalid && wready) begin obs_wdata = wdata; obs_wstrb = wstrb; end
      if (req_done != '0) begin
         obs_done_n++; obs_done_cyc = cyc; obs_done = req_done; obs_err = req_err;
      end
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      hs_b  = bvalid && bready;
      resp_now = bresp;
      // model advances across the coming rising edge
      m_done_exp = '0; m_err_exp = '0;
      if (m_busy) begin
         if (m_b_wait) begin
            if (bvalid) begin
               m_b_wait = 0; m_busy = 0;
               m_done_exp[m_idx] = 1'b1;
               m_err_exp[m_idx]  = (resp_now != 2'b00);
               m_ptr = (m_idx + 1) % N;
            end
         end else begin
            if (m_aw_pend && awready) m_aw_pend = 0;
            if (m_w_pend && wready) m_w_pend = 0;
            if (!m_aw_pend && !m_w_pend) m_b_wait = 1;
         end
      end else if (g >= 0) begin
         m_busy = 1; m_idx = g; m_aw_pend = 1; m_w_pend = 1;
         m_addr = BASE + (req_addr[g*32 +: 32] & 32'hFFFF_FFFC);
         m_data = req_data[g*32 +: 32];
         m_strb = req_strb[g*4 +: 4];
      end
      if (awvalid && !awready) aw_cnt++; else aw_cnt = 0;
      if (wvalid && !wready) w_cnt++; else w_cnt = 0;
      if (hs_aw) s_aw_seen = 1;
      if (hs_w) s_w_seen = 1;
      if (s_b_pend) begin
         if (hs_b) begin
            s_b_pend = 0;
            if (rnd) begin
               aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
               b_dly = $urandom_range(0, 3); b_resp = 2'($urandom_range(0, 3));
            end
         end else b_cnt++;
      end else if (s_aw_seen && s_w_seen) begin
         s_b_pend = 1; b_cnt = 0; s_aw_seen = 0; s_w_seen = 0;
      end
   endtask

   task automatic apply_reset();
      rst_n = 0;
      req_valid = d_valid; req_addr = d_addr; req_data = d_data; req_strb = d_strb;
      awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.ready", req_ready, '0);
      chk("rst.awvalid", awvalid, 1'b0);
      chk("rst.wvalid", wvalid, 1'b0);
      chk("rst.bready", bready, 1'b0);
      chk("rst.done", req_done, '0);
      chk("rst.err", req_err, '0);
      chk("rst.awaddr", awaddr, BASE);
      chk("rst.wdata", wdata, 32'h0);
      chk("rst.wstrb", wstrb, 4'h0);
      rst_n = 1;
   endtask

   task automatic run_vec(input vec_t v);
      logic [N-1:0] oh;
      oh = '0; oh[v.idx] = 1'b1;
      aw_dly = v.aw_dly; w_dly = v.w_dly; b_dly = v.b_dly; b_resp = v.resp;
      d_valid = oh;
      d_addr[v.idx*32 +: 32] = v.addr;
      d_data[v.idx*32 +: 32] = v.data;
      d_strb[v.idx*4 +: 4]   = v.strb;
      obs_clear();
      for (int c = 0; c < 20 && obs_acc_n == 0; c++) step();
      d_valid = '0;
      for (int c = 0; c < 40 && obs_done_n == 0; c++) step();
      chk("vec.accepts", obs_acc_n, 1);
      chk("vec.done_seen", obs_done_n, 1);
      chk("vec.awaddr", obs_awaddr, v.exp_awaddr);
      chk("vec.wdata", obs_wdata, v.data);
      chk("vec.wstrb", obs_wstrb, v.strb);
      chk("vec.aw_hi", obs_aw_hi, v.exp_aw_hi);
      chk("vec.w_hi", obs_w_hi, v.exp_w_hi);
      chk("vec.bready_lat", obs_br_cyc - obs_acc_cyc, v.exp_br);
      chk("vec.done_lat", obs_done_cyc - obs_acc_cyc, v.exp_lat);
      chk("vec.done_idx", obs_done, oh);
      chk("vec.err", obs_err, v.exp_err ? oh : '0);
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0, 32'h10,   32'h00AABBCC, 4'hF, 0, 0, 0, 2'b00, 32'h40000010, 1, 1, 2, 3, 1'b0};
      vecs[1] = '{0, 32'h100,  32'h12345678, 4'h3, 3, 0, 0, 2'b00, 32'h40000100, 4, 1, 5, 6, 1'b0};
      vecs[2] = '{1, 32'h20,   32'hDEADBEEF, 4'hC, 0, 0, 0, 2'b10, 32'h40000020, 1, 1, 2, 3, 1'b1};
      vecs[3] = '{1, 32'h13,   32'hCAFEF00D, 4'hF, 0, 0, 0, 2'b00, 32'h40000010, 1, 1, 2, 3, 1'b0};
      vecs[4] = '{0, 32'h40,   32'h0BADC0DE, 4'h5, 0, 2, 0, 2'b00, 32'h40000040, 1, 3, 4, 5, 1'b0};
      vecs[5] = '{1, 32'hFFFC, 32'h13579BDF, 4'h1, 2, 2, 2, 2'b11, 32'h4000FFFC, 3, 3, 4, 7, 1'b1};

      rst_n = 0;
      apply_reset();
      chk("const.awlen", awlen, 8'h00);
      chk("const.awsize", awsize, 3'h2);
      chk("const.awburst", awburst, 2'h1);
      chk("const.awlock", awlock, 1'b0);
      chk("const.awcache", awcache, 4'h2);
      chk("const.awprot", awprot, 3'h0);
      chk("const.awqos", awqos, 4'h0);
      repeat (3) step();

      // two requesters held valid: strict alternation from pointer 0
      d_valid = 2'b11;
      d_addr = {32'h204, 32'h104}; d_data = {32'hBBBB0001, 32'hAAAA0000}; d_strb = 8'hFF;
      obs_clear();
      for (int c = 0; c < 80 && obs_acc_n < 6; c++) step();
      d_valid = '0;
      for (int c = 0; c < 40 && obs_done_n < 6; c++) step();
      chk("rr.accepts", obs_acc_n, 6);
      chk("rr.dones", obs_done_n, 6);
      for (int i = 0; i < 6; i++)
         chk("rr.grant", (i < grant_log.size()) ? grant_log[i] : -1, i % 2);

      foreach (vecs[i]) run_vec(vecs[i]);

      // reset while req1's write waits for its B response
      aw_dly = 0; w_dly = 0; b_dly = 3; b_resp = 2'b00;
      d_valid = 2'b10; d_addr[63:32] = 32'h80; d_data[63:32] = 32'h55AA55AA;
      obs_clear();
      for (int c = 0; c < 30 && !obs_br_seen; c++) step();
      chk("arst.in_resp", bready, 1'b1);
      chk("arst.gidx", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
      #2 rst_n = 0;
      #1;
      chk("arst.awvalid", awvalid, 1'b0);
      chk("arst.wvalid", wvalid, 1'b0);
      chk("arst.bready", bready, 1'b0);
      chk("arst.done", req_done, '0);
      chk("arst.awaddr", awaddr, BASE);
      chk("arst.wdata", wdata, 32'h0);
      d_valid = 2'b11;
      apply_reset();
      obs_clear();
      for (int c = 0; c < 20 && obs_acc_n == 0; c++) step();
      d_valid = '0;
      chk("arst.first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
      for (int c = 0; c < 20 && m_busy; c++) step();

      // randomized traffic
      rnd = 1'b1;
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3); b_resp = 2'($urandom_range(0, 3));
      for (int c = 0; c < 800; c++) begin
         step();
         for (int i = 0; i < N; i++) begin
            if (last_hs[i] || (d_valid[i] && $urandom_range(0, 15) == 0)) d_valid[i] = 1'b0;
            if (!d_valid[i] && $urandom_range(0, 2) == 0) begin
               d_valid[i] = 1'b1;
               d_addr[i*32 +: 32] = $urandom;
               d_data[i*32 +: 32] = $urandom;
               d_strb[i*4 +: 4]   = 4'($urandom);
            end
         end
      end
      d_valid = '0;
      for (int c = 0; c < 40 && m_busy; c++) step();
      chk("drain.idle", m_busy, 1'b0);
      repeat (2) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
